// File: rtl/rgb2hsv_stream_pkg.sv
// Purpose: shared types and helpers for the streaming RGB->HSV converter.
// Contents: FSM state encoding, max-channel sector codes, default parameters,
//           clog2 / hue-width helpers used by the interface, top and divider.
package rgb2hsv_stream_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_DIV   = 3'd2,
      S_FINAL = 3'd3,
      S_HOLD  = 3'd4
   } state_e;

   // Which channel holds the maximum (ties resolved R > G > B).
   typedef enum logic [1:0] {
      SEC_R = 2'd0,
      SEC_G = 2'd1,
      SEC_B = 2'd2
   } sector_e;

   localparam int unsigned W_DEF          = 8;
   localparam int unsigned HUE_SECTOR_DEF = 60;
   localparam int unsigned USER_W_DEF     = 16;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   // Hue field width: enough for 0 .. 6*hue_sector-1.
   function automatic int unsigned hue_w(input int unsigned hue_sector);
      return clog2(6 * hue_sector);
   endfunction

endpackage

// File: rtl/rgb2hsv_stream_if.sv
// Purpose: pixel-in / HSV-out handshake bundle for rgb2hsv_stream.
// Signals: in_valid/in_ready/in_rgb{R,G,B}/in_user (pixel side),
//          out_valid/out_ready/out_hsv{H,S,V}/out_user/out_achrom (result side).
// Modports: slave = converter, master = pixel source and result sink.
interface rgb2hsv_stream_if
   import rgb2hsv_stream_pkg::*;
#(
   parameter int unsigned W          = W_DEF,
   parameter int unsigned HUE_SECTOR = HUE_SECTOR_DEF,
   parameter int unsigned USER_W     = USER_W_DEF
);
   localparam int unsigned HW = hue_w(HUE_SECTOR);

   logic                  in_valid;
   logic                  in_ready;
   logic [3*W-1:0]        in_rgb;
   logic [USER_W-1:0]     in_user;
   logic                  out_valid;
   logic                  out_ready;
   logic [HW+2*W-1:0]     out_hsv;
   logic [USER_W-1:0]     out_user;
   logic                  out_achrom;

   modport slave (
      input  in_valid, in_rgb, in_user, out_ready,
      output in_ready, out_valid, out_hsv, out_user, out_achrom
   );

   modport master (
      output in_valid, in_rgb, in_user, out_ready,
      input  in_ready, out_valid, out_hsv, out_user, out_achrom
   );

endinterface

// File: rtl/rgb2hsv_stream_div.sv
// Purpose: restoring radix-2 unsigned divider, one quotient bit per cycle.
// Ports: clk_i, rst_i (sync, active-high), start_i (load operands),
//        dividend_i/divisor_i (N bits), quotient_o (N bits, floor),
//        done_o (one-cycle pulse, N cycles after the start edge).
module rgb2hsv_stream_div
   import rgb2hsv_stream_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [N-1:0] dividend_i,
   input  logic [N-1:0] divisor_i,
   output logic [N-1:0] quotient_o,
   output logic         done_o
);
   localparam int unsigned CW = clog2(N + 1);

   logic [N-1:0]  rem_q;
   logic [N-1:0]  dvd_q;   // dividend bits shift out as quotient bits shift in
   logic [N-1:0]  dsr_q;
   logic [CW-1:0] cnt_q;
   logic          done_q;

   logic [N:0]    rem_sh;
   logic          ge;

   assign rem_sh = {rem_q, dvd_q[N-1]};
   assign ge     = (rem_sh >= {1'b0, dsr_q});

   // One restoring step per cycle while iterations remain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_q  <= '0;
         dvd_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (start_i) begin
         rem_q  <= '0;
         dvd_q  <= dividend_i;
         dsr_q  <= divisor_i;
         cnt_q  <= CW'(N);
         done_q <= 1'b0;
      end else if (cnt_q != '0) begin
         rem_q  <= ge ? N'(rem_sh - {1'b0, dsr_q}) : rem_sh[N-1:0];
         dvd_q  <= {dvd_q[N-2:0], ge};
         cnt_q  <= cnt_q - CW'(1);
         done_q <= (cnt_q == CW'(1));
      end else begin
         done_q <= 1'b0;
      end
   end

   assign quotient_o = dvd_q;
   assign done_o     = done_q;

endmodule

// File: rtl/rgb2hsv_stream.sv
// Purpose: streaming RGB->HSV converter, one pixel in flight, valid/ready on both sides.
// Ports: pclk, rst (sync, active-high), bus (rgb2hsv_stream_if.slave):
//        pixel in {R,G,B}+user, result out {H,S,V}+user+achrom, held until out_ready.
module rgb2hsv_stream
   import rgb2hsv_stream_pkg::*;
#(
   parameter int unsigned W          = W_DEF,
   parameter int unsigned HUE_SECTOR = HUE_SECTOR_DEF,
   parameter int unsigned USER_W     = USER_W_DEF
) (
   input  logic                pclk,
   input  logic                rst,
   rgb2hsv_stream_if.slave     bus
);
   localparam int unsigned HW       = hue_w(HUE_SECTOR);
   localparam int unsigned DW       = 2 * W;
   localparam int unsigned HUE_FULL = 6 * HUE_SECTOR;

   // Hue dividend HUE_SECTOR*num must fit the 2*W-bit divider.
   if (clog2(HUE_SECTOR + 1) + W > DW) begin : g_bad_params
      $error("rgb2hsv_stream: HUE_SECTOR too large for channel width W");
   end

   state_e            state_q, state_d;
   logic              div_start;
   logic              accept;

   logic [W-1:0]      r_q, g_q, b_q, max_q, min_q;
   sector_e           sec_q;
   logic [USER_W-1:0] user_q;
   logic [HW-1:0]     off_q;
   logic              neg_q, achrom_q;

   logic              out_valid_q, out_achrom_q;
   logic [HW+DW-1:0]  hsv_q;
   logic [USER_W-1:0] out_user_q;

   logic [W-1:0]      r_in, g_in, b_in, max_in, min_in;
   sector_e           sec_in;
   logic [W-1:0]      delta, num;
   logic              neg, achrom;
   logic [HW-1:0]     off;
   logic [DW-1:0]     hue_dvd, hue_dsr, sat_dvd, sat_dsr, hue_quo, sat_quo;
   logic              hue_done, sat_done;
   logic [HW-1:0]     h_raw, h_fin;
   logic [W-1:0]      s_fin;
   logic              unused_quo;

   assign r_in   = bus.in_rgb[3*W-1 -: W];
   assign g_in   = bus.in_rgb[2*W-1 -: W];
   assign b_in   = bus.in_rgb[W-1:0];
   assign accept = (state_q == S_IDLE) && bus.in_valid;

   // Max channel with R>G>B tie priority, plus plain minimum.
   always_comb begin
      sec_in = SEC_B;
      max_in = b_in;
      if (r_in >= g_in && r_in >= b_in) begin
         sec_in = SEC_R;
         max_in = r_in;
      end else if (g_in >= b_in) begin
         sec_in = SEC_G;
         max_in = g_in;
      end
      min_in = r_in;
      if (g_in < min_in) min_in = g_in;
      if (b_in < min_in) min_in = b_in;
   end

   // Pixel capture; no reset needed, only read after a fresh accept.
   always_ff @(posedge pclk) begin
      if (accept) begin
         r_q    <= r_in;
         g_q    <= g_in;
         b_q    <= b_in;
         max_q  <= max_in;
         min_q  <= min_in;
         sec_q  <= sec_in;
         user_q <= bus.in_user;
      end
      if (state_q == S_SETUP) begin
         off_q    <= off;
         neg_q    <= neg;
         achrom_q <= achrom;
      end
   end

   // Sector offset, hue numerator sign/magnitude and divider operands.
   always_comb begin
      delta  = max_q - min_q;
      achrom = (max_q == min_q);
      neg    = 1'b0;
      num    = '0;
      off    = '0;
      case (sec_q)
         SEC_R: begin
            neg = (g_q < b_q);
            num = neg ? (b_q - g_q) : (g_q - b_q);
            off = neg ? HW'(HUE_FULL) : '0;
         end
         SEC_G: begin
            neg = (b_q < r_q);
            num = neg ? (r_q - b_q) : (b_q - r_q);
            off = HW'(2 * HUE_SECTOR);
         end
         SEC_B: begin
            neg = (r_q < g_q);
            num = neg ? (g_q - r_q) : (r_q - g_q);
            off = HW'(4 * HUE_SECTOR);
         end
         default: ;
      endcase
      hue_dvd = achrom ? '0 : DW'(HUE_SECTOR) * DW'(num);
      hue_dsr = achrom ? DW'(1) : DW'(delta);
      sat_dvd = achrom ? '0 : DW'({W{1'b1}}) * DW'(delta);
      sat_dsr = achrom ? DW'(1) : DW'(max_q);
   end

   rgb2hsv_stream_div #(.N(DW)) u_hue_div (
      .clk_i      (pclk),
      .rst_i      (rst),
      .start_i    (div_start),
      .dividend_i (hue_dvd),
      .divisor_i  (hue_dsr),
      .quotient_o (hue_quo),
      .done_o     (hue_done)
   );

   rgb2hsv_stream_div #(.N(DW)) u_sat_div (
      .clk_i      (pclk),
      .rst_i      (rst),
      .start_i    (div_start),
      .dividend_i (sat_dvd),
      .divisor_i  (sat_dsr),
      .quotient_o (sat_quo),
      .done_o     (sat_done)
   );

   // Quotients are bounded by HUE_SECTOR and 2^W-1, so the narrowing is lossless.
   assign unused_quo = ^{hue_quo, sat_quo};

   // Final hue: a negative numerator near full scale can land exactly on HUE_FULL.
   always_comb begin
      h_raw = neg_q ? (off_q - HW'(hue_quo)) : (off_q + HW'(hue_quo));
      h_fin = (achrom_q || h_raw == HW'(HUE_FULL)) ? '0 : h_raw;
      s_fin = achrom_q ? '0 : W'(sat_quo);
   end

   // State register.
   always_ff @(posedge pclk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and divider start.
   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      case (state_q)
         S_IDLE:  if (bus.in_valid) state_d = S_SETUP;
         S_SETUP: begin
            div_start = 1'b1;
            state_d   = S_DIV;
         end
         S_DIV:   if (hue_done && sat_done) state_d = S_FINAL;
         S_FINAL: state_d = S_HOLD;
         S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Result registers, held through backpressure.
   always_ff @(posedge pclk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         hsv_q        <= '0;
         out_user_q   <= '0;
         out_achrom_q <= 1'b0;
      end else if (state_q == S_FINAL) begin
         out_valid_q  <= 1'b1;
         hsv_q        <= {h_fin, s_fin, max_q};
         out_user_q   <= user_q;
         out_achrom_q <= achrom_q;
      end else if (state_q == S_HOLD && bus.out_ready) begin
         out_valid_q  <= 1'b0;
      end
   end

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.out_valid  = out_valid_q;
   assign bus.out_hsv    = hsv_q;
   assign bus.out_user   = out_user_q;
   assign bus.out_achrom = out_achrom_q;

endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Purpose: directed self-checking bench for rgb2hsv_stream (W=8, HUE_SECTOR=60, USER_W=16).
module tb_rgb2hsv_stream;

   logic pclk;
   logic rst;
   int   n_checks;
   int   n_pass;

   rgb2hsv_stream_if #(.W(8), .HUE_SECTOR(60), .USER_W(16)) bus ();

   rgb2hsv_stream #(.W(8), .HUE_SECTOR(60), .USER_W(16)) dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d required %0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic accept_px(input int unsigned r, input int unsigned g, input int unsigned b,
                            input int unsigned user);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(posedge pclk); #1;
         guard++;
      end
      check_eq("accept_ready", 32'(bus.in_ready), 32'd1);
      bus.in_rgb   = {8'(r), 8'(g), 8'(b)};
      bus.in_user  = 16'(user);
      bus.in_valid = 1'b1;
      @(posedge pclk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge pclk); #1;
         lat++;
      end while (!bus.out_valid && lat < 60);
   endtask

   task automatic check_hsv(input string tag, input int unsigned h, input int unsigned s,
                            input int unsigned v, input int unsigned a, input int unsigned user);
      check_eq({tag, "_h"},    32'(bus.out_hsv[24:16]), 32'(h));
      check_eq({tag, "_s"},    32'(bus.out_hsv[15:8]),  32'(s));
      check_eq({tag, "_v"},    32'(bus.out_hsv[7:0]),   32'(v));
      check_eq({tag, "_ach"},  32'(bus.out_achrom),     32'(a));
      check_eq({tag, "_user"}, 32'(bus.out_user),       32'(user));
   endtask

   task automatic run_px(input string tag, input int unsigned r, input int unsigned g,
                         input int unsigned b, input int unsigned user, input int unsigned h,
                         input int unsigned s, input int unsigned v, input int unsigned a);
      int lat;
      accept_px(r, g, b, user);
      wait_out(lat);
      check_eq({tag, "_lat"}, 32'(lat), 32'd19);
      check_hsv(tag, h, s, v, a, user);
      @(posedge pclk); #1;
      check_eq({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
      check_eq({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int seen;
      n_checks      = 0;
      n_pass        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_rgb    = '0;
      bus.in_user   = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge pclk);
      #1;
      check_eq("rst_out_valid", 32'(bus.out_valid),  32'd0);
      check_eq("rst_out_hsv",   32'(bus.out_hsv),    32'd0);
      check_eq("rst_out_user",  32'(bus.out_user),   32'd0);
      check_eq("rst_achrom",    32'(bus.out_achrom), 32'd0);
      rst = 1'b0;
      check_eq("rst_in_ready",  32'(bus.in_ready),   32'd1);

      //      tag     R    G    B    user      H    S    V  ach
      run_px("orange", 255, 128,   0, 16'h0001,  30, 255, 255, 0);
      run_px("green",   10, 200,  50, 16'h0002, 132, 242, 200, 0);
      run_px("blue",     0,   0, 255, 16'h0003, 240, 255, 255, 0);
      run_px("grey",   100, 100, 100, 16'h0004,   0,   0, 100, 1);
      run_px("black",    0,   0,   0, 16'h0005,   0,   0,   0, 1);
      run_px("wrap0",  255,   0,   1, 16'h0006,   0, 255, 255, 0);
      run_px("mag",    255,   0, 128, 16'h0007, 330, 255, 255, 0);
      run_px("yellow", 255, 255,   0, 16'h0008,  60, 255, 255, 0);
      run_px("gneg",   200, 250, 100, 16'h0009,  80, 153, 250, 0);

      // Backpressure: result held for 10 cycles while a new pixel is offered.
      bus.out_ready = 1'b0;
      accept_px(255, 128, 0, 16'hBEEF);
      wait_out(lat);
      check_eq("bp_lat", 32'(lat), 32'd19);
      bus.in_rgb   = {8'd0, 8'd0, 8'd255};
      bus.in_user  = 16'h1234;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge pclk); #1;
         check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
         check_eq("bp_hsv",   32'(bus.out_hsv),   {7'd0, 9'd30, 8'd255, 8'd255});
         check_eq("bp_user",  32'(bus.out_user),  32'h0000BEEF);
         check_eq("bp_ready", 32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge pclk); #1;
      check_eq("bp_release_valid", 32'(bus.out_valid), 32'd0);
      check_eq("bp_release_ready", 32'(bus.in_ready),  32'd1);
      @(posedge pclk); #1;
      bus.in_valid = 1'b0;
      check_eq("bp_next_busy", 32'(bus.in_ready), 32'd0);
      wait_out(lat);
      check_eq("bp_next_lat", 32'(lat), 32'd19);
      check_hsv("bp_next", 240, 255, 255, 0, 16'h1234);
      @(posedge pclk); #1;

      // Reset while dividing: that pixel must never produce a result.
      accept_px(10, 200, 50, 16'h00AA);
      repeat (8) @(posedge pclk);
      #1;
      rst = 1'b1;
      @(posedge pclk); #1;
      rst = 1'b0;
      check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("midrst_ready", 32'(bus.in_ready),  32'd1);
      seen = 0;
      repeat (30) begin
         @(posedge pclk); #1;
         if (bus.out_valid) seen = 1;
      end
      check_eq("midrst_no_output", 32'(seen), 32'd0);
      run_px("after_rst", 255, 0, 128, 16'h0BAD, 330, 255, 255, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
